// File: rtl/isquare32.sv
// Sequential shift-and-add squarer: x = y*y after exactly WIDTH clocks.
// A synchronous reset edge loads the operand; rdy qualifies x.
module isquare32 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     y,
    output logic [2*WIDTH-1:0]   x,
    output logic                 rdy
);

    localparam int unsigned XW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [XW-1:0]      m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [XW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rdy_q, rdy_d;

    // Reset reloads the operand and restarts regardless of current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            m_q     <= XW'(y);
            q_q     <= y;
            acc_q   <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
        end
    end

    // One partial product per clock; latency is data-independent.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        rdy_d   = rdy_q;
        case (state_q)
            RUN: begin
                if (q_q[0]) begin
                    acc_d = acc_q + m_q;
                end
                m_d   = m_q << 1;
                q_d   = q_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    rdy_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = DONE;
            end
        endcase
    end

    assign x   = acc_q;
    assign rdy = rdy_q;

endmodule

// File: tb/tb_isquare32.sv
// Self-checking bench for isquare32: directed cases plus randomized operands
// checked against an arithmetic square and an integer-sqrt round trip.
module tb_isquare32;

    localparam int unsigned WIDTH = 16;

    logic                 clk;
    logic                 reset;
    logic [WIDTH-1:0]     y;
    logic [2*WIDTH-1:0]   x;
    logic                 rdy;

    int checks   = 0;
    int failures = 0;

    isquare32 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .y     (y),
        .x     (x),
        .rdy   (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference integer square root by bitwise search.
    function automatic longint unsigned ref_isqrt(input longint unsigned v);
        longint unsigned r = 0;
        for (int b = WIDTH - 1; b >= 0; b--) begin
            longint unsigned t = r | (longint'(1) << b);
            if (t * t <= v) r = t;
        end
        return r;
    endfunction

    task automatic start(input logic [WIDTH-1:0] yv);
        @(negedge clk);
        y     = yv;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_rdy", 64'(rdy), 64'd0);
        check("reset_x", 64'(x), 64'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Counts the reset edge's following negedge as already elapsed; waits the 16 edges.
    task automatic wait_done(input string tag, input longint unsigned exp, input bit check_rt);
        int early = 0;
        for (int i = 1; i <= WIDTH; i++) begin
            @(posedge clk);
            #1;
            if (i < WIDTH && rdy) early++;
        end
        check({tag, "_early"}, 64'(early), 64'd0);
        check({tag, "_rdy"}, 64'(rdy), 64'd1);
        check({tag, "_x"}, 64'(x), exp);
        if (check_rt) check({tag, "_rt"}, ref_isqrt(64'(x)), ref_isqrt(exp));
    endtask

    task automatic check_hold(input string tag, input longint unsigned exp, input int cycles);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (rdy !== 1'b1 || 64'(x) != exp) bad++;
        end
        check(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] ry;
        longint unsigned  sq;

        reset = 1'b1;
        y     = '0;
        repeat (2) @(posedge clk);

        start(16'd0);
        wait_done("y0", 0, 1'b0);
        check_hold("y0_hold", 0, 10);

        start(16'd1);
        wait_done("y1", 1, 1'b1);
        start(16'd3);
        wait_done("y3", 9, 1'b1);
        start(16'd4);
        wait_done("y4", 16, 1'b1);

        start(16'hFFFF);
        wait_done("ymax", 64'd4294836225, 1'b1);
        start(16'h8000);
        wait_done("ymsb", 64'd1073741824, 1'b1);

        // Abort a running computation with a new operand.
        start(16'd1000);
        repeat (5) @(posedge clk);
        start(16'd3);
        wait_done("abort", 9, 1'b0);

        // Operand changes after the reset edge must not leak in.
        start(16'd12345);
        y = 16'd54321;
        wait_done("iso", 64'd152399025, 1'b0);
        y = 16'd777;
        check_hold("iso_hold", 64'd152399025, 10);

        // Multi-cycle reset: the last sampled operand wins.
        @(negedge clk);
        y     = 16'd7;
        reset = 1'b1;
        @(negedge clk);
        y = 16'd5;
        @(posedge clk);
        #1;
        check("hold_rst_rdy", 64'(rdy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_done("hold_rst", 25, 1'b0);

        for (int n = 0; n < 200; n++) begin
            ry = WIDTH'($urandom);
            sq = longint'(ry) * longint'(ry);
            start(ry);
            wait_done("rand", sq, 1'b0);
            check("rand_rt", ref_isqrt(64'(x)), 64'(ry));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
